sdram_refresh_scheduler: RTL
============================

// Module: sdram_refresh_scheduler
// PURPOSE
//   Generates SDRAM auto-refresh requests toward the SDRAM command controller.
//   - Free-running interval counter; each terminal-count match against REFI_CYCLES adds one owed refresh ("debt").
//   - Refreshes are requested lazily while the controller is idle and forced (urgent) once debt reaches URGENT_TH.
//   - Sits beside the SDRAM controller FSM, which grants the request by issuing AUTO REFRESH and pulsing ref_ack.
// PARAMETERS
//   REFI_CYCLES  780  clocks per refresh interval (7.8 us @ 100 MHz); must be >= 2
//   CNT_W        16   interval counter width; 2**CNT_W > REFI_CYCLES
//   URGENT_TH    4    debt at/above which the request is forced (1..MAX_DEBT)
//   MAX_DEBT     8    debt saturation value (JEDEC postpone limit)
//   DEBT_W       4    debt width; 2**DEBT_W > MAX_DEBT
// PORTS
//   clk           in   1       system clock, rising edge
//   rst_n         in   1       asynchronous active-low reset
//   init_done     in   1       SDRAM power-up init complete; scheduler runs only while high
//   ctrl_idle     in   1       controller has no pending read/write; lazy refresh allowed
//   ref_ack       in   1       1-cycle pulse: controller issued one AUTO REFRESH
//   err_clr       in   1       clears overflow_err
//   ref_req       out  1       refresh requested
//   ref_urgent    out  1       debt >= URGENT_TH; controller must refresh before the next access
//   debt          out  DEBT_W  owed refreshes (registered)
//   overflow_err  out  1       sticky: interval elapsed while debt == MAX_DEBT
// BEHAVIOUR
//   Reset values (async, rst_n low):
//   - cnt = 0, debt = 0, state = IDLE, overflow_err = 0.
//   - ref_req = 0, ref_urgent = 0.
//   Interval counter:
//   - init_done = 0: cnt held at 0, debt cleared to 0, state forced to IDLE; overflow_err holds.
//   - init_done = 1: cnt increments each clock.
//   - tick = (cnt == REFI_CYCLES-1). On tick, cnt wraps to 0 on the same edge.
//   - Result: exactly one tick per REFI_CYCLES clocks.
//   Debt update (registered, one edge after the event):
//   - tick & !ack_v: debt + 1, saturating at MAX_DEBT.
//   - !tick & ack_v: debt - 1.
//   - tick & ack_v: debt unchanged (simultaneous events cancel).
//   - ack_v = ref_ack & (debt != 0). An ack with debt == 0 is ignored: no underflow, no error.
//   - tick while debt == MAX_DEBT: debt stays MAX_DEBT and overflow_err <= 1.
//   overflow_err:
//   - Sticky; cleared by err_clr.
//   - err_clr in the same cycle as a new overflow: set wins.
//   FSM (registered; derived from next debt value):
//   - IDLE: debt == 0.
//   - PEND: 0 < debt < URGENT_TH.
//   - URG: debt >= URGENT_TH.
//   - Transitions are IDLE<->PEND<->URG, one step per edge, since debt changes by at most 1.
//   - With URGENT_TH == 1, IDLE<->URG directly.
//   Outputs:
//   - ref_req = (state == URG) | (state == PEND & ctrl_idle).
//     Combinational from the state register and ctrl_idle; no added latency.
//   - ref_urgent = (state == URG).
//   - ref_req drops on the edge after the ack that brings debt to 0.
//   Handshake:
//   - One ref_ack per refresh; the controller may ack back-to-back.
//   - ref_req may deassert without an ack if ctrl_idle falls in PEND. This is legal.
//   - Reset or init_done low mid-request: ref_req drops immediately and pending debt is discarded.
// TESTING  (REFI_CYCLES=10, URGENT_TH=4, MAX_DEBT=8)
//   1. Reset: rst_n=0 asynchronously mid-count -> all outputs 0 without a clock edge.
//   2. Basic request and ack:
//      - Stimulus: init_done=1, ctrl_idle=1, no ack.
//      - Response: debt=1 and ref_req=1 after the 10th edge.
//      - Then pulse ref_ack -> debt=0, ref_req=0 on the next edge.
//   3. Urgent escalation:
//      - Stimulus: ctrl_idle=0, no ack.
//      - Response: ref_req=0 while debt is 1..3; at debt=4, ref_req=1 and ref_urgent=1.
//      - Then 4 acks -> debt=0, ref_urgent drops at debt=3.
//   4. Saturation and error:
//      - Stimulus: no acks for 9 intervals.
//      - Response: debt=8; overflow_err=1 on the 9th tick.
//      - err_clr=1 -> overflow_err=0; err_clr coincident with a tick at debt=8 -> overflow_err stays 1.
//   5. Simultaneous events:
//      - debt=3, ref_ack on the tick cycle -> debt stays 3.
//      - ref_ack with debt=0 -> debt stays 0, no error.
//   6. init_done drop: debt=5, init_done=0 -> next edge debt=0, cnt=0, ref_req=0; overflow_err unchanged.

Source files
------------

// File: rtl/sdram_refresh_scheduler.sv
// -----------------------------------------------------------------------------
// sdram_refresh_scheduler
//   Paces SDRAM auto-refresh. A free-running interval counter produces one tick
//   every REFI_CYCLES clocks. Each tick adds one owed refresh ("debt"), and each
//   acknowledged AUTO REFRESH removes one. Refresh is requested lazily while the
//   controller is idle, and forced (urgent) once debt reaches URGENT_TH.
//
// Ports
//   clk           in   1       system clock, rising edge
//   rst_n         in   1       asynchronous active-low reset
//   init_done     in   1       SDRAM init complete; scheduler runs only while high
//   ctrl_idle     in   1       controller has no pending access; lazy refresh ok
//   ref_ack       in   1       1-cycle pulse: controller issued one AUTO REFRESH
//   err_clr       in   1       clears overflow_err
//   ref_req       out  1       refresh requested
//   ref_urgent    out  1       debt >= URGENT_TH; refresh before next access
//   debt          out  DEBT_W  owed refreshes (registered)
//   overflow_err  out  1       sticky: interval elapsed while debt == MAX_DEBT
// -----------------------------------------------------------------------------
module sdram_refresh_scheduler #(
  parameter int REFI_CYCLES = 780,
  parameter int CNT_W       = 16,
  parameter int URGENT_TH   = 4,
  parameter int MAX_DEBT    = 8,
  parameter int DEBT_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              ctrl_idle,
  input  logic              ref_ack,
  input  logic              err_clr,
  output logic              ref_req,
  output logic              ref_urgent,
  output logic [DEBT_W-1:0] debt,
  output logic              overflow_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    URG  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFI_CYCLES - 1);
  localparam logic [DEBT_W-1:0] DEBT_MAX = DEBT_W'(MAX_DEBT);
  localparam logic [DEBT_W-1:0] DEBT_URG = DEBT_W'(URGENT_TH);

  logic [CNT_W-1:0]  cnt;
  state_t            state;
  state_t            state_nxt;
  logic [DEBT_W-1:0] debt_nxt;
  logic              tick;
  logic              ack_v;
  logic              ovf_set;

  // Gating tick with init_done keeps a stale terminal count from touching
  // overflow_err while the scheduler is held off.
  assign tick    = init_done & (cnt == CNT_LAST);
  // An ack with nothing owed is dropped so debt can never underflow.
  assign ack_v   = ref_ack & (debt != '0);
  // A tick at saturation means one refresh interval was lost.
  assign ovf_set = tick & (debt == DEBT_MAX);

  always_comb begin
    debt_nxt = debt;
    if (!init_done) begin
      debt_nxt = '0;
    end else if (tick && !ack_v) begin
      debt_nxt = (debt == DEBT_MAX) ? debt : debt + 1'b1;
    end else if (!tick && ack_v) begin
      debt_nxt = debt - 1'b1;
    end
  end

  // State tracks the debt value being registered this edge, so the request
  // outputs line up with the debt output with no extra latency.
  always_comb begin
    state_nxt = PEND;
    if (debt_nxt == '0) begin
      state_nxt = IDLE;
    end else if (debt_nxt >= DEBT_URG) begin
      state_nxt = URG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      debt         <= '0;
      state        <= IDLE;
      overflow_err <= 1'b0;
    end else begin
      cnt          <= (!init_done || tick) ? '0 : cnt + 1'b1;
      debt         <= debt_nxt;
      state        <= state_nxt;
      // Set has priority over a coincident clear.
      overflow_err <= ovf_set | (overflow_err & ~err_clr);
    end
  end

  assign ref_urgent = (state == URG);
  assign ref_req    = (state == URG) | ((state == PEND) & ctrl_idle);

endmodule
